// File: rtl/acc_pkg.sv
// Shared definitions for the accumulate sequencer: FSM state encoding and
// the index-width helpers used to size counters and interface fields.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OUT  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Width of an index that spans 0..count-1, never narrower than one bit.
  function automatic int idx_w(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Control/status bundle between the accumulate sequencer and its datapath.
// The master drives run control and operand availability; the slave sequences.
interface acc_seq_ctrl_if
  import acc_pkg::*;
#(
  parameter int TAPS    = 4,
  parameter int NEURONS = 10
);

  localparam int TAP_W = idx_w(TAPS);
  localparam int NRN_W = idx_w(NEURONS);

  logic             start;
  logic             abort;
  logic             in_valid;
  logic             sel;
  logic             acc_en;
  logic             en;
  logic [TAP_W-1:0] tap_idx;
  logic [NRN_W-1:0] nrn_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, in_valid,
    input  sel, acc_en, en, tap_idx, nrn_idx, busy, done
  );

  modport slave (
    input  start, abort, in_valid,
    output sel, acc_en, en, tap_idx, nrn_idx, busy, done
  );

endinterface

// File: rtl/mod_counter.sv
// Saturating up-counter 0..MAX with synchronous clear; `last` flags MAX so the
// owner can decide what happens at the end of the range.
module mod_counter
  import acc_pkg::*;
#(
  parameter  int MAX = 3,
  localparam int W   = idx_w(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         last
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign last = (q_q == W'(MAX));
  assign q    = q_q;

  // Increment is suppressed at MAX so the index can never wrap.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !last) begin
      q_d = q_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequencer that walks TAPS operand pairs per neuron for NEURONS neurons,
// emitting accumulator load/add strobes, a per-neuron write and an end pulse.
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int TAPS    = 4,
  parameter int NEURONS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  acc_seq_ctrl_if.slave bus
);

  localparam int TAP_W = idx_w(TAPS);
  localparam int NRN_W = idx_w(NEURONS);

  state_e state_q;
  state_e state_d;

  logic             tap_clr;
  logic             tap_inc;
  logic             tap_last;
  logic [TAP_W-1:0] tap_q;

  logic             nrn_clr;
  logic             nrn_inc;
  logic             nrn_last;
  logic [NRN_W-1:0] nrn_q;

  mod_counter #(.MAX(TAPS - 1)) u_tap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tap_clr),
    .inc   (tap_inc),
    .q     (tap_q),
    .last  (tap_last)
  );

  mod_counter #(.MAX(NEURONS - 1)) u_nrn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (nrn_clr),
    .inc   (nrn_inc),
    .q     (nrn_q),
    .last  (nrn_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    tap_clr = 1'b0;
    tap_inc = 1'b0;
    nrn_clr = 1'b0;
    nrn_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        tap_clr = 1'b1;
        nrn_clr = 1'b1;
        if (bus.start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          tap_clr = 1'b1;
          nrn_clr = 1'b1;
        end else if (bus.in_valid) begin
          if (tap_last) begin
            state_d = OUT;
          end else begin
            tap_inc = 1'b1;
          end
        end
      end

      OUT: begin
        if (bus.abort) begin
          state_d = IDLE;
          tap_clr = 1'b1;
          nrn_clr = 1'b1;
        end else if (nrn_last) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          tap_clr = 1'b1;
          nrn_inc = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        tap_clr = 1'b1;
        nrn_clr = 1'b1;
      end

      default: begin
        state_d = IDLE;
        tap_clr = 1'b1;
        nrn_clr = 1'b1;
      end
    endcase
  end

  // Strobes decode straight from state so reset clears them without a clock.
  assign bus.acc_en  = (state_q == RUN) && bus.in_valid;
  assign bus.sel     = (state_q == RUN) && bus.in_valid && (tap_q == '0);
  assign bus.en      = (state_q == OUT);
  assign bus.done    = (state_q == DONE);
  assign bus.busy    = (state_q == RUN) || (state_q == OUT);
  assign bus.tap_idx = tap_q;
  assign bus.nrn_idx = nrn_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: a default-sized and a 1x1 instance share stimulus and
// are compared every cycle against an operand-count reference model.
module tb_acc_seq_ctrl;
  import acc_pkg::*;

  localparam int T0 = 4;
  localparam int N0 = 10;
  localparam int T1 = 1;
  localparam int N1 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;

  always #5 clk = ~clk;

  acc_seq_ctrl_if #(.TAPS(T0), .NEURONS(N0)) bus0 ();
  acc_seq_ctrl_if #(.TAPS(T1), .NEURONS(N1)) bus1 ();

  assign bus0.start    = start;
  assign bus0.abort    = abort;
  assign bus0.in_valid = in_valid;
  assign bus1.start    = start;
  assign bus1.abort    = abort;
  assign bus1.in_valid = in_valid;

  acc_seq_ctrl #(.TAPS(T0), .NEURONS(N0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  acc_seq_ctrl #(.TAPS(T1), .NEURONS(N1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: a run is a count of consumed operand pairs; the tap and neuron
  // are ops % taps and ops / taps, plus pending write and end-of-run flags.
  typedef struct {
    int taps;
    int nrns;
    bit active;
    bit out_p;
    bit done_p;
    int ops;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset(input int taps, input int nrns);
    mdl_t m;
    m.taps = taps; m.nrns = nrns;
    m.active = 1'b0; m.out_p = 1'b0; m.done_p = 1'b0; m.ops = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit st, input bit ab, input bit iv);
    mdl_t r;
    r = m;
    if (m.done_p) begin
      r.done_p = 1'b0;
    end else if (!m.active) begin
      if (st) begin
        r.active = 1'b1; r.ops = 0; r.out_p = 1'b0;
      end
    end else if (ab) begin
      r.active = 1'b0; r.out_p = 1'b0;
    end else if (m.out_p) begin
      r.out_p = 1'b0;
      if (m.ops == m.taps * m.nrns) begin
        r.active = 1'b0; r.done_p = 1'b1;
      end
    end else if (iv) begin
      r.ops = m.ops + 1;
      if (r.ops % m.taps == 0) r.out_p = 1'b1;
    end
    return r;
  endfunction

  task automatic check_outputs(input string pfx, input mdl_t m, input bit iv,
                               input logic s, input logic ae, input logic e,
                               input logic b, input logic d,
                               input logic [31:0] tap, input logic [31:0] nrn);
    bit run;
    int exp_tap, exp_nrn;
    run = m.active && !m.out_p;
    check({pfx, ".acc_en"}, {31'b0, ae}, {31'b0, run && iv});
    check({pfx, ".sel"},    {31'b0, s},  {31'b0, run && iv && (m.ops % m.taps == 0)});
    check({pfx, ".en"},     {31'b0, e},  {31'b0, m.active && m.out_p});
    check({pfx, ".busy"},   {31'b0, b},  {31'b0, m.active});
    check({pfx, ".done"},   {31'b0, d},  {31'b0, m.done_p});
    if (!m.done_p) begin
      exp_tap = !m.active ? 0 : (m.out_p ? m.taps - 1 : m.ops % m.taps);
      exp_nrn = !m.active ? 0 : (m.out_p ? (m.ops - 1) / m.taps : m.ops / m.taps);
      check({pfx, ".tap_idx"}, tap, exp_tap);
      check({pfx, ".nrn_idx"}, nrn, exp_nrn);
    end
  endtask

  int cyc;
  int en0_cnt, busy0_cnt, en0_first, done0_cyc, done1_cyc, done0_cnt;

  task automatic clear_rec();
    en0_cnt = 0; busy0_cnt = 0; en0_first = -1; done0_cyc = -1; done1_cyc = -1; done0_cnt = 0;
  endtask

  // One clock: check outputs mid-cycle, advance models at the edge, then
  // return #1 after the edge so the caller can set next-cycle inputs.
  task automatic cycle();
    @(negedge clk);
    check_outputs("d0", m0, in_valid, bus0.sel, bus0.acc_en, bus0.en, bus0.busy, bus0.done,
                  32'(bus0.tap_idx), 32'(bus0.nrn_idx));
    check_outputs("d1", m1, in_valid, bus1.sel, bus1.acc_en, bus1.en, bus1.busy, bus1.done,
                  32'(bus1.tap_idx), 32'(bus1.nrn_idx));
    if (bus0.en) begin
      en0_cnt++;
      if (en0_first < 0) en0_first = cyc;
    end
    if (bus0.busy) busy0_cnt++;
    if (bus0.done) begin
      done0_cnt++;
      if (done0_cyc < 0) done0_cyc = cyc;
    end
    if (bus1.done && done1_cyc < 0) done1_cyc = cyc;
    @(posedge clk);
    m0 = mdl_step(m0, start, abort, in_valid);
    m1 = mdl_step(m1, start, abort, in_valid);
    cyc++;
    #1;
  endtask

  initial begin
    int k;
    m0 = mdl_reset(T0, N0);
    m1 = mdl_reset(T1, N1);
    clear_rec();
    cyc = 0;

    // Reset state before any clock edge.
    #1;
    check_outputs("rst0", m0, 1'b0, bus0.sel, bus0.acc_en, bus0.en, bus0.busy, bus0.done,
                  32'(bus0.tap_idx), 32'(bus0.nrn_idx));
    check_outputs("rst1", m1, 1'b0, bus1.sel, bus1.acc_en, bus1.en, bus1.busy, bus1.done,
                  32'(bus1.tap_idx), 32'(bus1.nrn_idx));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full run with in_valid held; stray start pulses in RUN and DONE.
    clear_rec();
    cyc = 0; start = 1'b1; in_valid = 1'b1;
    cycle();
    for (int i = 0; i < 60; i++) begin
      start = (cyc == 20 || cyc == 51);
      cycle();
    end
    start = 1'b0;
    check("latency_d0", done0_cyc, 51);
    check("done_count_d0", done0_cnt, 1);
    check("en_count_d0", en0_cnt, N0);
    check("en_first_d0", en0_first, 5);
    check("busy_cycles_d0", busy0_cnt, 50);
    check("latency_d1", done1_cyc, 3);
    repeat (6) cycle();

    // Stall three cycles at tap 2 of neuron 0.
    clear_rec();
    cyc = 0; start = 1'b1; in_valid = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = !(cyc >= 3 && cyc <= 5);
      cycle();
    end
    in_valid = 1'b1;
    check("stall_en_first", en0_first, 8);
    repeat (50) cycle();

    // Abort while neuron 3 is accumulating.
    clear_rec();
    start = 1'b1; in_valid = 1'b1;
    cycle();
    start = 1'b0;
    k = 0;
    while (!(bus0.nrn_idx == 3 && bus0.acc_en) && k < 40) begin
      cycle();
      k++;
    end
    check("abort_reach", {31'b0, k < 40}, 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    clear_rec();
    repeat (20) cycle();
    check("abort_no_en", en0_cnt, 0);
    check("abort_no_done", done0_cnt, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("restart_nrn", 32'(bus0.nrn_idx), 0);
    check("restart_tap", 32'(bus0.tap_idx), 0);

    // Asynchronous reset while a neuron write is showing.
    k = 0;
    while (!bus0.en && k < 20) begin
      cycle();
      k++;
    end
    check("out_reach", {31'b0, bus0.en}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_en", {31'b0, bus0.en}, 0);
    check("async_busy", {31'b0, bus0.busy}, 0);
    check("async_nrn", 32'(bus0.nrn_idx), 0);
    m0 = mdl_reset(T0, N0);
    m1 = mdl_reset(T1, N1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("post_rst_busy", {31'b0, bus0.busy}, 1);

    // Randomized control traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

Interface
REQ-001 SHALL have parameter TAPS, default 4, products accumulated per neuron (legal range 1..65535).
REQ-002 SHALL have parameter NEURONS, default 10, neurons sequenced per run (legal range 1..4096).
REQ-003 SHALL have derived localparams TAP_W = max(1,clog2(TAPS)) and NRN_W = max(1,clog2(NEURONS)).
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: start  input  1  begin a run; sampled only in IDLE.
REQ-007 SHALL have port: abort  input  1  synchronous cancel of a run in progress.
REQ-008 SHALL have port: in_valid  input  1  operand pair available this cycle; low stalls.
REQ-009 SHALL have port: sel  output  1  accumulator load (first tap) instead of add.
REQ-010 SHALL have port: acc_en  output  1  accumulator update strobe.
REQ-011 SHALL have port: en  output  1  neuron result write strobe.
REQ-012 SHALL have port: tap_idx  output  TAP_W  current tap / weight address.
REQ-013 SHALL have port: nrn_idx  output  NRN_W  current neuron index.
REQ-014 SHALL have port: busy  output  1  high in RUN and OUT.
REQ-015 SHALL have port: done  output  1  one-cycle end-of-run pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, OUT, DONE.
REQ-017 IDLE: start=1 -> RUN with tap_idx=0, nrn_idx=0; start=0 -> stay.
REQ-018 RUN: in_valid=1 and tap_idx<TAPS-1 -> tap_idx+1; in_valid=1 and tap_idx=TAPS-1 -> OUT; in_valid=0 -> hold all state.
REQ-019 OUT (exactly one cycle): nrn_idx<NEURONS-1 -> nrn_idx+1, tap_idx=0, RUN; else -> DONE.
REQ-020 DONE (exactly one cycle): -> IDLE with tap_idx=0, nrn_idx=0.
REQ-021 Outputs combinational from state/counters: acc_en = RUN & in_valid; sel = RUN & in_valid & (tap_idx=0); en = OUT; done = DONE; busy = RUN | OUT.
REQ-022 TAPS=1: sel and acc_en assert in the same cycle, then OUT follows next cycle.
REQ-023 start outside IDLE SHALL be ignored, including in DONE.
REQ-024 abort=1 in RUN or OUT -> IDLE next edge, counters cleared; abort has priority over all transitions; no en/done produced for the aborted neuron/run; abort in IDLE/DONE ignored.
REQ-025 Counters SHALL never exceed TAPS-1 / NEURONS-1; no wrap beyond these.
REQ-026 With in_valid constantly 1, latency from start edge to done SHALL be NEURONS*(TAPS+1)+1 cycles.

Reset
REQ-027 rst_n=0 SHALL immediately, without clock, force IDLE, tap_idx=0, nrn_idx=0, so sel=acc_en=en=busy=done=0.
REQ-028 Reset mid-run SHALL discard the run; first rising edge after rst_n release samples start normally.

Structure
REQ-029 Package acc_pkg SHALL hold state encoding (IDLE=2'b00, RUN=2'b01, OUT=2'b10, DONE=2'b11) and the clog2 function.
REQ-030 Sub-module mod_counter (parameter MAX; ports clk, rst_n, clr, inc, q, last) SHALL implement both tap and neuron counters.

Verification
REQ-031 Defaults, start at cycle 0, in_valid=1 -> sel at cycles 1,6,...,46; en at 5,10,...,50; busy 1..50; done only at 51.
REQ-032 Stall: in_valid=0 for 3 cycles while tap_idx=2 -> tap_idx holds 2, acc_en=0 for those cycles, en for neuron 0 at cycle 8.
REQ-033 TAPS=1, NEURONS=1 -> sel=acc_en=1 cycle 1, en cycle 2, done cycle 3, IDLE cycle 4.
REQ-034 abort while nrn_idx=3 in RUN -> IDLE next cycle, no further en, no done; next start restarts at nrn_idx=0, tap_idx=0.
REQ-035 rst_n low asynchronously during OUT -> en, busy drop before next clock edge; start pulse in RUN or DONE -> no effect on sequence.
